// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle between the cache controllers / AXI bridge and the memory bus arbiter.
// The slave modport is the arbiter's view; master is the view of everything around it.
interface mem_bus_arbiter_if;
  logic        i_rd_req;
  logic [31:0] i_rd_addr;
  logic [3:0]  i_rd_len;
  logic        i_rd_gnt;
  logic        i_rd_valid;
  logic        i_rd_last;
  logic        d_rd_req;
  logic [31:0] d_rd_addr;
  logic [3:0]  d_rd_len;
  logic        d_rd_gnt;
  logic        d_rd_valid;
  logic        d_rd_last;
  logic [31:0] rd_data;
  logic        d_wr_req;
  logic [31:0] d_wr_addr;
  logic [3:0]  d_wr_len;
  logic        d_wr_gnt;
  logic [31:0] d_wr_data;
  logic [3:0]  d_wr_strb;
  logic        d_wr_dvalid;
  logic        d_wr_dready;
  logic        d_wr_done;
  logic        m_rd_req;
  logic [31:0] m_rd_addr;
  logic [3:0]  m_rd_len;
  logic        m_rd_id;
  logic        m_rd_ack;
  logic        m_rd_valid;
  logic [31:0] m_rd_data;
  logic        m_rd_last;
  logic        m_wr_req;
  logic [31:0] m_wr_addr;
  logic [3:0]  m_wr_len;
  logic        m_wr_ack;
  logic [31:0] m_wr_data;
  logic [3:0]  m_wr_strb;
  logic        m_wr_valid;
  logic        m_wr_last;
  logic        m_wr_ready;
  logic        m_wr_resp;

  modport slave (
    input  i_rd_req, i_rd_addr, i_rd_len, d_rd_req, d_rd_addr, d_rd_len,
           d_wr_req, d_wr_addr, d_wr_len, d_wr_data, d_wr_strb, d_wr_dvalid,
           m_rd_ack, m_rd_valid, m_rd_data, m_rd_last, m_wr_ack, m_wr_ready, m_wr_resp,
    output i_rd_gnt, i_rd_valid, i_rd_last, d_rd_gnt, d_rd_valid, d_rd_last, rd_data,
           d_wr_gnt, d_wr_dready, d_wr_done,
           m_rd_req, m_rd_addr, m_rd_len, m_rd_id,
           m_wr_req, m_wr_addr, m_wr_len, m_wr_data, m_wr_strb, m_wr_valid, m_wr_last
  );

  modport master (
    output i_rd_req, i_rd_addr, i_rd_len, d_rd_req, d_rd_addr, d_rd_len,
           d_wr_req, d_wr_addr, d_wr_len, d_wr_data, d_wr_strb, d_wr_dvalid,
           m_rd_ack, m_rd_valid, m_rd_data, m_rd_last, m_wr_ack, m_wr_ready, m_wr_resp,
    input  i_rd_gnt, i_rd_valid, i_rd_last, d_rd_gnt, d_rd_valid, d_rd_last, rd_data,
           d_wr_gnt, d_wr_dready, d_wr_done,
           m_rd_req, m_rd_addr, m_rd_len, m_rd_id,
           m_wr_req, m_wr_addr, m_wr_len, m_wr_data, m_wr_strb, m_wr_valid, m_wr_last
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one external memory port between ICache reads, DCache reads and DCache writes.
// Independent read and write FSMs; D-priority read arbitration with I starvation guard and RAW hold.
module mem_bus_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int LINE_OFF_W   = 5
) (
  input  logic          clk,
  input  logic          reset,
  mem_bus_arbiter_if.slave bus
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_t;
  typedef struct packed {logic [31:0] addr; logic [3:0] len; logic id;} rd_cmd_t;
  typedef struct packed {logic [31:0] addr; logic [3:0] len;} wr_cmd_t;

  rd_state_t     rd_state, rd_next;
  wr_state_t     wr_state, wr_next;
  rd_cmd_t       rd_cmd, rd_cmd_next;
  wr_cmd_t       wr_cmd, wr_cmd_next;
  logic [CW-1:0] starve_cnt, starve_next;
  logic [3:0]    beat, beat_next;
  logic          i_gnt, d_gnt, w_gnt, w_done;

  // A D read to the line currently being written back must wait for the write response.
  logic wr_busy, raw_hit, d_elig, i_wins, d_wins;
  assign wr_busy = (wr_state != W_IDLE);
  assign raw_hit = wr_busy && (bus.d_rd_addr[31:LINE_OFF_W] == wr_cmd.addr[31:LINE_OFF_W]);
  assign d_elig  = bus.d_rd_req && !raw_hit;
  assign i_wins  = bus.i_rd_req && (!d_elig || (starve_cnt == LIMIT));
  assign d_wins  = d_elig && !i_wins;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state   <= R_IDLE;
      rd_cmd     <= '0;
      starve_cnt <= '0;
    end else begin
      rd_state   <= rd_next;
      rd_cmd     <= rd_cmd_next;
      starve_cnt <= starve_next;
    end
  end

  always_comb begin
    rd_next     = rd_state;
    rd_cmd_next = rd_cmd;
    starve_next = starve_cnt;
    i_gnt       = 1'b0;
    d_gnt       = 1'b0;
    case (rd_state)
      R_IDLE: begin
        if (i_wins) begin
          i_gnt       = 1'b1;
          rd_cmd_next = '{addr: bus.i_rd_addr, len: bus.i_rd_len, id: 1'b0};
          starve_next = '0;
          rd_next     = R_ADDR;
        end else if (d_wins) begin
          d_gnt       = 1'b1;
          rd_cmd_next = '{addr: bus.d_rd_addr, len: bus.d_rd_len, id: 1'b1};
          if (bus.i_rd_req && (starve_cnt != LIMIT)) starve_next = starve_cnt + 1'b1;
          rd_next     = R_ADDR;
        end
      end
      R_ADDR:  if (bus.m_rd_ack) rd_next = R_DATA;
      R_DATA:  if (bus.m_rd_valid && bus.m_rd_last) rd_next = R_IDLE;
      default: rd_next = R_IDLE;
    endcase
  end

  assign bus.i_rd_gnt   = i_gnt && !reset;
  assign bus.d_rd_gnt   = d_gnt && !reset;
  assign bus.m_rd_req   = (rd_state == R_ADDR);
  assign bus.m_rd_addr  = rd_cmd.addr;
  assign bus.m_rd_len   = rd_cmd.len;
  assign bus.m_rd_id    = rd_cmd.id;
  assign bus.i_rd_valid = (rd_state == R_DATA) && bus.m_rd_valid && !rd_cmd.id;
  assign bus.d_rd_valid = (rd_state == R_DATA) && bus.m_rd_valid &&  rd_cmd.id;
  assign bus.i_rd_last  = bus.i_rd_valid && bus.m_rd_last;
  assign bus.d_rd_last  = bus.d_rd_valid && bus.m_rd_last;
  assign bus.rd_data    = bus.m_rd_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_state <= W_IDLE;
      wr_cmd   <= '0;
      beat     <= '0;
    end else begin
      wr_state <= wr_next;
      wr_cmd   <= wr_cmd_next;
      beat     <= beat_next;
    end
  end

  always_comb begin
    wr_next     = wr_state;
    wr_cmd_next = wr_cmd;
    beat_next   = beat;
    w_gnt       = 1'b0;
    w_done      = 1'b0;
    case (wr_state)
      W_IDLE: begin
        if (bus.d_wr_req) begin
          w_gnt       = 1'b1;
          wr_cmd_next = '{addr: bus.d_wr_addr, len: bus.d_wr_len};
          beat_next   = '0;
          wr_next     = W_ADDR;
        end
      end
      W_ADDR: if (bus.m_wr_ack) wr_next = W_DATA;
      W_DATA: begin
        if (bus.d_wr_dvalid && bus.m_wr_ready) begin
          beat_next = beat + 1'b1;
          if (beat == wr_cmd.len) wr_next = W_RESP;
        end
      end
      W_RESP: begin
        if (bus.m_wr_resp) begin
          w_done  = 1'b1;
          wr_next = W_IDLE;
        end
      end
      default: wr_next = W_IDLE;
    endcase
  end

  assign bus.d_wr_gnt    = w_gnt && !reset;
  assign bus.d_wr_done   = w_done && !reset;
  assign bus.m_wr_req    = (wr_state == W_ADDR);
  assign bus.m_wr_addr   = wr_cmd.addr;
  assign bus.m_wr_len    = wr_cmd.len;
  assign bus.m_wr_valid  = (wr_state == W_DATA) && bus.d_wr_dvalid;
  assign bus.d_wr_dready = (wr_state == W_DATA) && bus.m_wr_ready;
  assign bus.m_wr_last   = (wr_state == W_DATA) && (beat == wr_cmd.len);
  assign bus.m_wr_data   = bus.d_wr_data;
  assign bus.m_wr_strb   = bus.d_wr_strb;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: arbitration, starvation guard, RAW hold, write beats, reset, ack stall.
module tb_mem_bus_arbiter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_bus_arbiter_if bus();
  mem_bus_arbiter #(.STARVE_LIMIT(4), .LINE_OFF_W(5)) dut (.clk(clk), .reset(reset), .bus(bus));

  int vecs = 0;
  int errs = 0;

  task automatic clear_inputs();
    bus.i_rd_req = 0; bus.i_rd_addr = '0; bus.i_rd_len = '0;
    bus.d_rd_req = 0; bus.d_rd_addr = '0; bus.d_rd_len = '0;
    bus.d_wr_req = 0; bus.d_wr_addr = '0; bus.d_wr_len = '0;
    bus.d_wr_data = '0; bus.d_wr_strb = '0; bus.d_wr_dvalid = 0;
    bus.m_rd_ack = 0; bus.m_rd_valid = 0; bus.m_rd_data = '0; bus.m_rd_last = 0;
    bus.m_wr_ack = 0; bus.m_wr_ready = 0; bus.m_wr_resp = 0;
  endtask

  // Bus-side read responder: called at a negedge with the read FSM in R_ADDR.
  task automatic serve_read(input int beats);
    bus.m_rd_ack = 1; @(negedge clk); bus.m_rd_ack = 0;
    for (int b = 0; b < beats; b++) begin
      bus.m_rd_valid = 1; bus.m_rd_data = 32'hD000_0000 + b; bus.m_rd_last = (b == beats - 1);
      @(negedge clk);
    end
    bus.m_rd_valid = 0; bus.m_rd_last = 0;
  endtask

  task automatic test_reset();
    clear_inputs(); reset = 1; bus.i_rd_req = 1; bus.d_wr_req = 1;
    repeat (2) @(negedge clk);
    #1;
    vecs++; if (bus.i_rd_gnt !== 1'b0) begin errs++; $display("FAIL rst_i_gnt: got %b want 0", bus.i_rd_gnt); end
    vecs++; if (bus.d_wr_gnt !== 1'b0) begin errs++; $display("FAIL rst_w_gnt: got %b want 0", bus.d_wr_gnt); end
    vecs++; if ({bus.m_rd_req, bus.m_rd_addr, bus.m_rd_len, bus.m_rd_id} !== 38'h0) begin errs++;
      $display("FAIL rst_m_rd: got req=%b addr=%h len=%h id=%b want all 0", bus.m_rd_req, bus.m_rd_addr, bus.m_rd_len, bus.m_rd_id); end
    vecs++; if ({bus.m_wr_req, bus.m_wr_valid, bus.m_wr_addr, bus.m_wr_len} !== 38'h0) begin errs++;
      $display("FAIL rst_m_wr: got req=%b valid=%b addr=%h len=%h want all 0", bus.m_wr_req, bus.m_wr_valid, bus.m_wr_addr, bus.m_wr_len); end
    clear_inputs(); reset = 0;
  endtask

  task automatic test_priority();
    @(negedge clk);
    bus.i_rd_req = 1; bus.i_rd_addr = 32'h2000_0000; bus.i_rd_len = 4'd1;
    bus.d_rd_req = 1; bus.d_rd_addr = 32'h3000_0000; bus.d_rd_len = 4'd1;
    #1;
    vecs++; if (bus.d_rd_gnt !== 1'b1) begin errs++; $display("FAIL prio_d_gnt: got %b want 1", bus.d_rd_gnt); end
    vecs++; if (bus.i_rd_gnt !== 1'b0) begin errs++; $display("FAIL prio_i_gnt: got %b want 0", bus.i_rd_gnt); end
    @(negedge clk); bus.d_rd_req = 0; #1;
    vecs++; if ({bus.m_rd_req, bus.m_rd_id, bus.m_rd_addr} !== {1'b1, 1'b1, 32'h3000_0000}) begin errs++;
      $display("FAIL prio_m_rd: got req=%b id=%b addr=%h want 1 1 30000000", bus.m_rd_req, bus.m_rd_id, bus.m_rd_addr); end
    bus.m_rd_ack = 1; @(negedge clk); bus.m_rd_ack = 0;
    bus.m_rd_valid = 1; bus.m_rd_data = 32'hCAFE_0001; bus.m_rd_last = 0; #1;
    vecs++; if ({bus.d_rd_valid, bus.d_rd_last, bus.i_rd_valid} !== 3'b100) begin errs++;
      $display("FAIL prio_beat0: got dv=%b dl=%b iv=%b want 1 0 0", bus.d_rd_valid, bus.d_rd_last, bus.i_rd_valid); end
    vecs++; if (bus.rd_data !== 32'hCAFE_0001) begin errs++; $display("FAIL prio_data: got %h want cafe0001", bus.rd_data); end
    @(negedge clk); bus.m_rd_data = 32'hCAFE_0002; bus.m_rd_last = 1; #1;
    vecs++; if ({bus.d_rd_valid, bus.d_rd_last} !== 2'b11) begin errs++;
      $display("FAIL prio_last: got dv=%b dl=%b want 1 1", bus.d_rd_valid, bus.d_rd_last); end
    @(negedge clk); bus.m_rd_valid = 0; bus.m_rd_last = 0; #1;
    vecs++; if (bus.i_rd_gnt !== 1'b1) begin errs++; $display("FAIL prio_i_after: got %b want 1", bus.i_rd_gnt); end
    @(negedge clk); bus.i_rd_req = 0; #1;
    vecs++; if ({bus.m_rd_id, bus.m_rd_addr} !== {1'b0, 32'h2000_0000}) begin errs++;
      $display("FAIL prio_i_cmd: got id=%b addr=%h want 0 20000000", bus.m_rd_id, bus.m_rd_addr); end
    serve_read(2);
  endtask

  task automatic test_starve();
    @(negedge clk);
    bus.i_rd_req = 1; bus.i_rd_addr = 32'h2000_0100; bus.i_rd_len = 0;
    bus.d_rd_addr = 32'h3000_0100; bus.d_rd_len = 0;
    for (int k = 0; k < 5; k++) begin
      bus.d_rd_req = 1; #1;
      vecs++; if ({bus.d_rd_gnt, bus.i_rd_gnt} !== ((k < 4) ? 2'b10 : 2'b01)) begin errs++;
        $display("FAIL starve_round%0d: got d=%b i=%b want %s", k, bus.d_rd_gnt, bus.i_rd_gnt, (k < 4) ? "D" : "I"); end
      @(negedge clk);
      if (k < 4) bus.d_rd_req = 0; else bus.i_rd_req = 0;
      serve_read(1);
    end
    // I just won, so the counter restarts: D beats a fresh I request again.
    bus.i_rd_req = 1; #1;
    vecs++; if ({bus.d_rd_gnt, bus.i_rd_gnt} !== 2'b10) begin errs++;
      $display("FAIL starve_cleared: got d=%b i=%b want D", bus.d_rd_gnt, bus.i_rd_gnt); end
    @(negedge clk); bus.d_rd_req = 0; serve_read(1); #1;
    vecs++; if (bus.i_rd_gnt !== 1'b1) begin errs++; $display("FAIL starve_i_next: got %b want 1", bus.i_rd_gnt); end
    @(negedge clk); bus.i_rd_req = 0; serve_read(1);
  endtask

  task automatic test_raw();
    @(negedge clk);
    bus.d_wr_req = 1; bus.d_wr_addr = 32'h1000_0040; bus.d_wr_len = 4'd7; #1;
    vecs++; if (bus.d_wr_gnt !== 1'b1) begin errs++; $display("FAIL raw_w_gnt: got %b want 1", bus.d_wr_gnt); end
    @(negedge clk); bus.d_wr_req = 0;
    bus.d_rd_req = 1; bus.d_rd_addr = 32'h1000_0050; bus.d_rd_len = 0;
    bus.i_rd_req = 1; bus.i_rd_addr = 32'h4000_0000; bus.i_rd_len = 0; #1;
    vecs++; if ({bus.m_wr_req, bus.m_wr_addr, bus.m_wr_len} !== {1'b1, 32'h1000_0040, 4'd7}) begin errs++;
      $display("FAIL raw_m_wr: got req=%b addr=%h len=%h want 1 10000040 7", bus.m_wr_req, bus.m_wr_addr, bus.m_wr_len); end
    vecs++; if ({bus.d_rd_gnt, bus.i_rd_gnt} !== 2'b01) begin errs++;
      $display("FAIL raw_i_wins: got d=%b i=%b want I only", bus.d_rd_gnt, bus.i_rd_gnt); end
    @(negedge clk); bus.i_rd_req = 0; serve_read(1); #1;
    vecs++; if (bus.d_rd_gnt !== 1'b0) begin errs++; $display("FAIL raw_hold_waddr: got %b want 0", bus.d_rd_gnt); end
    bus.m_wr_ack = 1; @(negedge clk); bus.m_wr_ack = 0;
    bus.d_wr_dvalid = 1; bus.m_wr_ready = 1; bus.d_wr_strb = 4'hF;
    repeat (8) @(negedge clk);
    bus.d_wr_dvalid = 0; bus.m_wr_ready = 0; #1;
    vecs++; if ({bus.d_rd_gnt, bus.d_wr_done} !== 2'b00) begin errs++;
      $display("FAIL raw_hold_resp: got gnt=%b done=%b want 0 0", bus.d_rd_gnt, bus.d_wr_done); end
    bus.m_wr_resp = 1; #1;
    vecs++; if ({bus.d_wr_done, bus.d_rd_gnt} !== 2'b10) begin errs++;
      $display("FAIL raw_done: got done=%b gnt=%b want 1 0", bus.d_wr_done, bus.d_rd_gnt); end
    @(negedge clk); bus.m_wr_resp = 0; #1;
    vecs++; if (bus.d_rd_gnt !== 1'b1) begin errs++; $display("FAIL raw_release: got %b want 1", bus.d_rd_gnt); end
    @(negedge clk); bus.d_rd_req = 0; #1;
    vecs++; if ({bus.m_rd_id, bus.m_rd_addr} !== {1'b1, 32'h1000_0050}) begin errs++;
      $display("FAIL raw_d_cmd: got id=%b addr=%h want 1 10000050", bus.m_rd_id, bus.m_rd_addr); end
    serve_read(1);
  endtask

  task automatic test_write_toggle();
    int beats = 0;
    int dones = 0;
    @(negedge clk);
    bus.d_wr_req = 1; bus.d_wr_addr = 32'h5000_0000; bus.d_wr_len = 4'd3; #1;
    vecs++; if (bus.d_wr_gnt !== 1'b1) begin errs++; $display("FAIL wt_gnt: got %b want 1", bus.d_wr_gnt); end
    @(negedge clk); bus.d_wr_req = 0; bus.m_wr_ack = 1;
    @(negedge clk); bus.m_wr_ack = 0;
    for (int c = 0; c < 20 && beats < 4; c++) begin
      bus.d_wr_dvalid = 1; bus.d_wr_strb = 4'hF; bus.d_wr_data = 32'h100 + beats;
      bus.m_wr_ready = (c % 2 == 1); #1;
      vecs++; if (bus.d_wr_dready !== (c % 2 == 1)) begin errs++;
        $display("FAIL wt_dready c%0d: got %b want %0d", c, bus.d_wr_dready, c % 2); end
      if (bus.m_wr_valid && bus.m_wr_ready) begin
        vecs++; if ({bus.m_wr_last, bus.m_wr_data} !== {(beats == 3), 32'h100 + beats}) begin errs++;
          $display("FAIL wt_beat%0d: got last=%b data=%h want last=%0d data=%h", beats, bus.m_wr_last, bus.m_wr_data, beats == 3, 32'h100 + beats); end
        beats++;
      end
      @(negedge clk);
    end
    vecs++; if (beats !== 4) begin errs++; $display("FAIL wt_beats: got %0d want 4", beats); end
    bus.d_wr_dvalid = 0; bus.m_wr_ready = 0;
    for (int c = 0; c < 4; c++) begin
      bus.m_wr_resp = (c == 1); #1;
      if (bus.d_wr_done) dones++;
      @(negedge clk);
    end
    bus.m_wr_resp = 0;
    vecs++; if (dones !== 1) begin errs++; $display("FAIL wt_done_count: got %0d want 1", dones); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.d_rd_req = 1; bus.d_rd_addr = 32'h7000_0000; bus.d_rd_len = 4'd7;
    bus.d_wr_req = 1; bus.d_wr_addr = 32'h7100_0000; bus.d_wr_len = 4'd1; #1;
    vecs++; if ({bus.d_rd_gnt, bus.d_wr_gnt} !== 2'b11) begin errs++;
      $display("FAIL rm_gnts: got rd=%b wr=%b want 1 1", bus.d_rd_gnt, bus.d_wr_gnt); end
    @(negedge clk); bus.d_rd_req = 0; bus.d_wr_req = 0; bus.m_rd_ack = 1;
    @(negedge clk); bus.m_rd_ack = 0;
    for (int b = 0; b < 2; b++) begin
      bus.m_rd_valid = 1; bus.m_rd_last = 0; bus.m_rd_data = 32'hB0 + b; @(negedge clk);
    end
    reset = 1;
    @(negedge clk); #1;
    vecs++; if ({bus.m_rd_req, bus.m_rd_addr, bus.m_rd_len, bus.m_rd_id} !== 38'h0) begin errs++;
      $display("FAIL rm_m_rd: got req=%b addr=%h len=%h id=%b want all 0", bus.m_rd_req, bus.m_rd_addr, bus.m_rd_len, bus.m_rd_id); end
    vecs++; if ({bus.d_rd_valid, bus.d_rd_last, bus.i_rd_valid} !== 3'b000) begin errs++;
      $display("FAIL rm_valid: got dv=%b dl=%b iv=%b want 0 0 0", bus.d_rd_valid, bus.d_rd_last, bus.i_rd_valid); end
    vecs++; if ({bus.m_wr_req, bus.m_wr_addr, bus.d_wr_done} !== 34'h0) begin errs++;
      $display("FAIL rm_m_wr: got req=%b addr=%h done=%b want all 0", bus.m_wr_req, bus.m_wr_addr, bus.d_wr_done); end
    reset = 0; bus.m_rd_valid = 0;
    bus.i_rd_req = 1; bus.i_rd_addr = 32'h0000_1000; bus.i_rd_len = 0; #1;
    vecs++; if (bus.i_rd_gnt !== 1'b1) begin errs++; $display("FAIL rm_idle_gnt: got %b want 1", bus.i_rd_gnt); end
    @(negedge clk); bus.i_rd_req = 0; serve_read(1);
  endtask

  task automatic test_ack_delay();
    int extra = 0;
    @(negedge clk);
    bus.i_rd_req = 1; bus.i_rd_addr = 32'h6000_0020; bus.i_rd_len = 4'd5; #1;
    vecs++; if (bus.i_rd_gnt !== 1'b1) begin errs++; $display("FAIL ad_gnt: got %b want 1", bus.i_rd_gnt); end
    @(negedge clk); bus.i_rd_req = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      vecs++; if ({bus.m_rd_req, bus.m_rd_addr, bus.m_rd_len, bus.m_rd_id} !== {1'b1, 32'h6000_0020, 4'd5, 1'b0}) begin errs++;
        $display("FAIL ad_stable c%0d: got req=%b addr=%h len=%h id=%b want 1 60000020 5 0", c, bus.m_rd_req, bus.m_rd_addr, bus.m_rd_len, bus.m_rd_id); end
      if (bus.i_rd_gnt) extra++;
      @(negedge clk);
    end
    vecs++; if (extra !== 0) begin errs++; $display("FAIL ad_single_gnt: got %0d extra pulses want 0", extra); end
    serve_read(6);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_priority();
    test_starve();
    test_raw();
    test_write_toggle();
    test_reset_mid();
    test_ack_delay();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
